instr_fetch: RTL

- Instruction fetch front end. Generates instruction-memory addresses, runs a req/ack handshake with instruction memory, and buffers returned words in a small prefetch FIFO.
- Drives Instrn/Latch_Instr into the downstream instruction latch, one instruction per accepted cycle.
- Handles pipeline stall and taken-branch redirect, including discard of in-flight fetch data.

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/fetch_buf.sv | 65 ++++++
 rtl/instr_fetch.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_FULL = 2'd1,
    S_DROP = 2'd2
  } ifetch_state_e;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0;

endpackage

// File: rtl/fetch_buf.sv
// Prefetch FIFO holding {pc, word} pairs; flush overrides push and pop.
module fetch_buf
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Flush,
  input  logic                       Push,
  input  logic                       Pop,
  input  logic [ADDR_W-1:0]          Push_Pc,
  input  logic [31:0]                Push_Word,
  output logic [ADDR_W-1:0]          Head_Pc,
  output logic [31:0]                Head_Word,
  output logic                       Full,
  output logic                       Empty,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [31:0]       word_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              do_push;
  logic              do_pop;

  assign Full  = (count_reg == CNT_W'(DEPTH));
  assign Empty = (count_reg == '0);
  assign Count = count_reg;

  // A push into a full buffer is only accepted when the head leaves on the same edge.
  assign do_push = Push && !Flush && (!Full || Pop);
  assign do_pop  = Pop && !Flush && !Empty;

  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) begin
      pc_mem[wr_ptr_reg]   <= Push_Pc;
      word_mem[wr_ptr_reg] <= Push_Word;
    end
  end

  assign Head_Pc   = pc_mem[rd_ptr_reg];
  assign Head_Word = word_mem[rd_ptr_reg];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: address generation, one-outstanding req/ack
// handshake with instruction memory, prefetch buffering and branch redirect.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              Imem_Req,
  output logic [ADDR_W-1:0] Imem_Addr,
  input  logic              Imem_Ack,
  input  logic [31:0]       Imem_Data,
  input  logic              Stall,
  input  logic              Branch_Taken,
  input  logic [ADDR_W-1:0] Branch_Target,
  output logic [31:0]       Instrn,
  output logic              Latch_Instr,
  output logic [ADDR_W-1:0] Instrn_PC
);

  localparam int                CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INSTR_BYTES);

  ifetch_state_e     state_reg, state_next;
  logic [ADDR_W-1:0] req_addr_reg, req_addr_next;
  logic [ADDR_W-1:0] fetch_addr_reg, fetch_addr_next;
  logic [ADDR_W-1:0] target_aligned;
  logic              req_active;
  logic              ack_seen;
  logic              push;
  logic              pop;
  logic              buf_full;
  logic              buf_empty;
  logic [CNT_W-1:0]  buf_count;
  logic [CNT_W-1:0]  count_after;
  logic [ADDR_W-1:0] head_pc;
  logic [31:0]       head_word;

  // An ack only counts while a request is actually on the bus.
  assign req_active     = !Reset && (state_reg != S_FULL);
  assign ack_seen       = req_active && Imem_Ack;
  assign push           = (state_reg == S_REQ) && ack_seen && !Branch_Taken;
  assign pop            = !Reset && !buf_empty && !Stall && !Branch_Taken;
  assign target_aligned = Branch_Target & ~ADDR_W'(3);
  assign count_after    = buf_count + CNT_W'(push) - CNT_W'(pop);

  fetch_buf #(
    .ADDR_W (ADDR_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .Clk       (Clk),
    .Reset     (Reset),
    .Flush     (Branch_Taken),
    .Push      (push),
    .Pop       (pop),
    .Push_Pc   (req_addr_reg),
    .Push_Word (Imem_Data),
    .Head_Pc   (head_pc),
    .Head_Word (head_word),
    .Full      (buf_full),
    .Empty     (buf_empty),
    .Count     (buf_count)
  );

  always_comb begin
    state_next      = state_reg;
    req_addr_next   = req_addr_reg;
    fetch_addr_next = fetch_addr_reg;

    if (Branch_Taken) begin
      fetch_addr_next = target_aligned + STEP;
      // A request still waiting for its ack must finish before the target can go out.
      if (state_reg != S_FULL && !ack_seen) begin
        fetch_addr_next = target_aligned;
        state_next      = S_DROP;
      end else begin
        req_addr_next = target_aligned;
        state_next    = S_REQ;
      end
    end else begin
      case (state_reg)
        S_REQ: begin
          if (ack_seen) begin
            req_addr_next   = fetch_addr_reg;
            fetch_addr_next = fetch_addr_reg + STEP;
          end
          if (count_after == CNT_W'(BUF_DEPTH))
            state_next = S_FULL;
        end
        S_FULL: begin
          if (pop || !buf_full)
            state_next = S_REQ;
        end
        S_DROP: begin
          if (ack_seen) begin
            req_addr_next   = fetch_addr_reg;
            fetch_addr_next = fetch_addr_reg + STEP;
            state_next      = S_REQ;
          end
        end
        default: state_next = S_REQ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg      <= S_REQ;
      req_addr_reg   <= RESET_PC;
      fetch_addr_reg <= RESET_PC + STEP;
    end else begin
      state_reg      <= state_next;
      req_addr_reg   <= req_addr_next;
      fetch_addr_reg <= fetch_addr_next;
    end
  end

  assign Imem_Req    = req_active;
  assign Imem_Addr   = req_addr_reg;
  assign Latch_Instr = pop;
  assign Instrn      = buf_empty ? NOP_INSTR : head_word;
  assign Instrn_PC   = buf_empty ? '0 : head_pc;

endmodule
